// File: rtl/seq_mem_d1_responder_if.sv
//------------------------------------------------------------------------------
// Module  : seq_mem_d1_responder_if
// Purpose : Request/response bundle between a Calyx-style initiator and
//           the seq_mem_d1_responder memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_mem_d1_responder_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] addr0;
  logic [WIDTH-1:0]    write_data;
  logic                write_en;
  logic                read_en;
  logic [WIDTH-1:0]    read_data;
  logic                done;
  logic                busy;
  logic                oob_err;

  modport master (
    output addr0, write_data, write_en, read_en,
    input  read_data, done, busy, oob_err
  );

  modport slave (
    input  addr0, write_data, write_en, read_en,
    output read_data, done, busy, oob_err
  );
endinterface

`default_nettype wire

// File: rtl/seq_mem_d1_responder.sv
//------------------------------------------------------------------------------
// Module  : seq_mem_d1_responder
// Purpose : 1-D memory responder with read enable, fixed LATENCY access time
//           and a one-cycle done pulse. Optional macro: SEQ_MEM_OOB_CHECK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_mem_d1_responder #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_mem_d1_responder_if.slave  mem_if
);

  localparam int            CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_WAIT   = 1'b1;

  logic [WIDTH-1:0]    mem_q [SIZE];
  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                is_wr_q;
  logic                oob_q;
  logic [WIDTH-1:0]    rdata_q, rdata_d;

  logic                w_req;
  logic                w_done;
  logic                w_accept;
  logic                w_oob_in;
  logic                w_commit;
  logic                w_ld_en;
  logic [IDX_SIZE-1:0] w_ld_addr;
  logic                w_ld_oob;

  assign w_req    = mem_if.write_en | mem_if.read_en;
  assign w_done   = (state_q == S_WAIT) && (cnt_q == '0);
  assign w_accept = ((state_q == S_IDLE) || w_done) && w_req;
  assign w_commit = w_done && is_wr_q && !oob_q;

`ifdef SEQ_MEM_OOB_CHECK_EN
  localparam logic [IDX_SIZE:0] SIZE_C = (IDX_SIZE+1)'(SIZE);
  assign w_oob_in = ({1'b0, mem_if.addr0} >= SIZE_C);
`else
  assign w_oob_in = 1'b0;
`endif

  // read_data is loaded on the edge that opens the read's done cycle
  generate
    if (LATENCY == 1) begin : g_ld_direct
      assign w_ld_en   = w_accept && !mem_if.write_en;
      assign w_ld_addr = mem_if.addr0;
      assign w_ld_oob  = w_oob_in;
    end else begin : g_ld_wait
      assign w_ld_en   = (state_q == S_WAIT) && (cnt_q == CNT_W'(1)) && !is_wr_q;
      assign w_ld_addr = addr_q;
      assign w_ld_oob  = oob_q;
    end
  endgenerate

  always_comb begin
    rdata_d = rdata_q;
    if (w_ld_en) begin
      if (w_ld_oob)
        rdata_d = '0;
      else if (w_commit && (addr_q == w_ld_addr))
        rdata_d = wdata_q;
      else
        rdata_d = mem_q[w_ld_addr];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      state_d = S_WAIT;
      cnt_d   = CNT_LOAD;
    end else if (w_done) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (w_accept) begin
        addr_q  <= mem_if.addr0;
        wdata_q <= mem_if.write_data;
        is_wr_q <= mem_if.write_en;
        oob_q   <= w_oob_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_commit)
      mem_q[addr_q] <= wdata_q;
  end

  // Output logic
  always_comb begin
    mem_if.done = w_done;
    mem_if.busy = (state_q == S_WAIT) && (cnt_q != '0);
  end

  assign mem_if.read_data = rdata_q;

`ifdef SEQ_MEM_OOB_CHECK_EN
  logic oob_err_q;
  always_ff @(posedge clk) begin
    if (reset)
      oob_err_q <= 1'b0;
    else if (w_accept && w_oob_in)
      oob_err_q <= 1'b1;
  end
  assign mem_if.oob_err = oob_err_q;
`else
  assign mem_if.oob_err = 1'b0;
`endif

endmodule

`default_nettype wire
